// File: rtl/bus_reg_file.sv
// Register file on a shared, priority-encoded datapath bus, with conflict
// detection and a three-state engine that moves one source into one register.
module bus_reg_file #(
   parameter  int WIDTH    = 32,
   parameter  int NUM_REGS = 16,
   localparam int SEL_W    = $clog2(NUM_REGS + 1)
) (
   input  logic                clk,
   input  logic                clr,
   input  logic [NUM_REGS-1:0] out_en,
   input  logic                ext_out,
   input  logic [WIDTH-1:0]    ext_data,
   input  logic [NUM_REGS-1:0] in_en,
   output logic [WIDTH-1:0]    bus_data,
   output logic [SEL_W-1:0]    bus_sel,
   output logic                conflict,
   output logic                conflict_seen,
   input  logic                conflict_clr,
   input  logic [SEL_W-1:0]    rd_addr,
   output logic [WIDTH-1:0]    rd_data,
   input  logic                xfer_start,
   input  logic [SEL_W-1:0]    xfer_src,
   input  logic [SEL_W-1:0]    xfer_dst,
   output logic                xfer_busy,
   output logic                xfer_done,
   output logic                xfer_err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [SEL_W-1:0] MAX_IDX = SEL_W'(NUM_REGS);

   state_t              state_q, state_d;
   logic [SEL_W-1:0]    src_q, src_d;
   logic [SEL_W-1:0]    dst_q, dst_d;
   logic                conflict_seen_q, conflict_seen_d;
   logic [WIDTH-1:0]    regs_q [NUM_REGS];
   logic [WIDTH-1:0]    regs_d [NUM_REGS];

   logic [NUM_REGS:0]   src_vec;
   logic [WIDTH-1:0]    src_val [NUM_REGS+1];
   logic [NUM_REGS-1:0] wr_en;
   logic                xfer_bad;
   logic                driving;

   assign driving  = (state_q == ST_DRIVE);
   assign xfer_bad = (src_q > MAX_IDX) || (dst_q == '0) || (dst_q > MAX_IDX);

   // Transfer engine: capture on start, one bus cycle, one completion cycle.
   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case can leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      unique case (state_q)
         ST_IDLE: begin
            if (xfer_start) begin
               src_d   = xfer_src;
               dst_d   = xfer_dst;
               state_d = ST_DRIVE;
            end
         end
         ST_DRIVE: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   assign xfer_busy = (state_q != ST_IDLE);
   assign xfer_done = (state_q == ST_DONE);
   assign xfer_err  = (state_q == ST_DONE) && xfer_bad;

   // Source vector and write enables: the engine owns both during DRIVE,
   // and an invalid request leaves the bus idle and writes nothing.
   always_comb begin
      src_vec = '0;
      wr_en   = '0;
      if (driving) begin
         if (!xfer_bad) begin
            for (int i = 0; i <= NUM_REGS; i++) begin
               if (src_q == SEL_W'(i)) src_vec[i] = 1'b1;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
               if (dst_q == SEL_W'(i + 1)) wr_en[i] = 1'b1;
            end
         end
      end else begin
         src_vec = {out_en, ext_out};
         wr_en   = in_en;
      end
   end

   always_comb begin
      src_val[0] = ext_data;
      for (int i = 0; i < NUM_REGS; i++) begin
         src_val[i+1] = regs_q[i];
      end
   end

   // Ascending scan: the last asserted index seen, i.e. the highest, wins.
   always_comb begin
      bus_sel  = '0;
      bus_data = '0;
      for (int i = 0; i <= NUM_REGS; i++) begin
         if (src_vec[i]) begin
            bus_sel  = SEL_W'(i);
            bus_data = src_val[i];
         end
      end
   end

   assign conflict = !driving && ($countones(src_vec) > 1);

   always_comb begin
      conflict_seen_d = conflict_seen_q;
      if (conflict_clr) conflict_seen_d = 1'b0;
      if (conflict)     conflict_seen_d = 1'b1;
   end

   assign conflict_seen = conflict_seen_q;

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = wr_en[i] ? bus_data : regs_q[i];
      end
   end

   always_comb begin
      rd_data = '0;
      if (rd_addr == '0) rd_data = ext_data;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_addr == SEL_W'(i + 1)) rd_data = regs_q[i];
      end
   end

   // NOTE: flops use non-blocking assignments so every register samples the
   // pre-edge values, independent of statement order.
   // NOTE: the register array is reset because software observes the cleared
   // contents after clr; it is small enough to live in flops, not a RAM macro.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q         <= ST_IDLE;
         src_q           <= '0;
         dst_q           <= '0;
         conflict_seen_q <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q         <= state_d;
         src_q           <= src_d;
         dst_q           <= dst_d;
         conflict_seen_q <= conflict_seen_d;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

endmodule

// File: tb/tb_bus_reg_file.sv
// Scoreboard bench for bus_reg_file: a directed sequence followed by random
// traffic, all predicted by a behavioural model and checked by a monitor.
module tb_bus_reg_file;

   localparam int W  = 32;
   localparam int NR = 16;
   localparam int SW = $clog2(NR + 1);

   logic          clk = 1'b0;
   logic          clr;
   logic [NR-1:0] out_en, in_en;
   logic          ext_out;
   logic [W-1:0]  ext_data;
   logic [W-1:0]  bus_data;
   logic [SW-1:0] bus_sel;
   logic          conflict, conflict_seen, conflict_clr;
   logic [SW-1:0] rd_addr;
   logic [W-1:0]  rd_data;
   logic          xfer_start;
   logic [SW-1:0] xfer_src, xfer_dst;
   logic          xfer_busy, xfer_done, xfer_err;

   bus_reg_file #(.WIDTH(W), .NUM_REGS(NR)) dut (
      .clk(clk), .clr(clr), .out_en(out_en), .ext_out(ext_out),
      .ext_data(ext_data), .in_en(in_en), .bus_data(bus_data),
      .bus_sel(bus_sel), .conflict(conflict), .conflict_seen(conflict_seen),
      .conflict_clr(conflict_clr), .rd_addr(rd_addr), .rd_data(rd_data),
      .xfer_start(xfer_start), .xfer_src(xfer_src), .xfer_dst(xfer_dst),
      .xfer_busy(xfer_busy), .xfer_done(xfer_done), .xfer_err(xfer_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          clr;
      logic [NR-1:0] out_en;
      logic          ext_out;
      logic [W-1:0]  ext_data;
      logic [NR-1:0] in_en;
      logic          cclr;
      logic [SW-1:0] rd_addr;
      logic          start;
      logic [SW-1:0] src;
      logic [SW-1:0] dst;
   } stim_t;

   typedef struct {
      logic [W-1:0]  bus;
      logic [SW-1:0] sel;
      logic          conf;
      logic          seen;
      logic [W-1:0]  rd;
      logic          busy;
      logic          done;
      logic          err;
   } exp_t;

   exp_t sb[$];

   // Reference model: register contents, sticky flag, and transfer phase
   // (0 = idle, 1 = bus cycle, 2 = completion cycle).
   logic [W-1:0] m_reg [NR];
   logic         m_seen;
   int           m_phase, m_src, m_dst;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [W-1:0] src_value(input int i, input stim_t s);
      return (i == 0) ? s.ext_data : m_reg[i-1];
   endfunction

   function automatic stim_t idle_stim(input int rd);
      stim_t s;
      s.clr = 0; s.out_en = '0; s.ext_out = 0; s.ext_data = '0; s.in_en = '0;
      s.cclr = 0; s.rd_addr = SW'(rd); s.start = 0; s.src = '0; s.dst = '0;
      return s;
   endfunction

   task automatic drive(input stim_t s);
      exp_t e;
      int   cnt, top;
      bit   bad;
      @(posedge clk);
      #1;
      clr = s.clr; out_en = s.out_en; ext_out = s.ext_out; ext_data = s.ext_data;
      in_en = s.in_en; conflict_clr = s.cclr; rd_addr = s.rd_addr;
      xfer_start = s.start; xfer_src = s.src; xfer_dst = s.dst;

      if (s.clr) begin
         foreach (m_reg[i]) m_reg[i] = '0;
         m_seen = 0; m_phase = 0; m_src = 0; m_dst = 0;
      end
      bad = (m_src > NR) || (m_dst == 0) || (m_dst > NR);

      if (m_phase == 1) begin
         e.sel  = bad ? '0 : SW'(m_src);
         e.bus  = bad ? '0 : src_value(m_src, s);
         e.conf = 0;
      end else begin
         cnt = 0; top = -1;
         if (s.ext_out) begin cnt++; top = 0; end
         for (int i = 0; i < NR; i++) if (s.out_en[i]) begin cnt++; top = i + 1; end
         e.sel  = (top < 0) ? '0 : SW'(top);
         e.bus  = (top < 0) ? '0 : src_value(top, s);
         e.conf = (cnt >= 2);
      end
      e.seen = m_seen;
      e.busy = (m_phase != 0);
      e.done = (m_phase == 2);
      e.err  = (m_phase == 2) && bad;
      if (s.rd_addr == 0)       e.rd = s.ext_data;
      else if (s.rd_addr <= NR) e.rd = m_reg[s.rd_addr-1];
      else                      e.rd = '0;
      sb.push_back(e);

      if (!s.clr) begin
         if (m_phase == 1) begin
            if (!bad) m_reg[m_dst-1] = e.bus;
         end else begin
            for (int i = 0; i < NR; i++) if (s.in_en[i]) m_reg[i] = e.bus;
         end
         if (e.conf)      m_seen = 1;
         else if (s.cclr) m_seen = 0;
         case (m_phase)
            0: if (s.start) begin m_src = s.src; m_dst = s.dst; m_phase = 1; end
            1: m_phase = 2;
            default: m_phase = 0;
         endcase
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("bus_data",      bus_data,      e.bus);
         check("bus_sel",       bus_sel,       e.sel);
         check("conflict",      conflict,      e.conf);
         check("conflict_seen", conflict_seen, e.seen);
         check("rd_data",       rd_data,       e.rd);
         check("xfer_busy",     xfer_busy,     e.busy);
         check("xfer_done",     xfer_done,     e.done);
         check("xfer_err",      xfer_err,      e.err);
      end
   end

   function automatic stim_t rand_stim();
      stim_t         s;
      logic [NR-1:0] one = 1;
      int            mode;
      s = idle_stim($urandom_range(0, NR + 2));
      s.ext_data = $urandom;
      mode = $urandom_range(0, 9);
      if (mode < 6) begin
         if ($urandom_range(0, 4) == 0) s.ext_out = 1;
         else s.out_en = one << $urandom_range(0, NR - 1);
      end else if (mode >= 8) begin
         s.out_en  = (one << $urandom_range(0, NR - 1)) | (one << $urandom_range(0, NR - 1));
         s.ext_out = $urandom_range(0, 1);
      end
      case ($urandom_range(0, 5))
         0, 1:    s.in_en = one << $urandom_range(0, NR - 1);
         2:       s.in_en = NR'($urandom);
         default: s.in_en = '0;
      endcase
      s.cclr  = ($urandom_range(0, 7) == 0);
      s.start = ($urandom_range(0, 3) == 0);
      s.src   = SW'($urandom_range(0, NR + 1));
      s.dst   = SW'($urandom_range(0, NR + 1));
      s.clr   = ($urandom_range(0, 99) == 0);
      return s;
   endfunction

   initial begin
      stim_t s;
      clr = 1; out_en = '0; ext_out = 0; ext_data = '0; in_en = '0;
      conflict_clr = 0; rd_addr = '0; xfer_start = 0; xfer_src = '0; xfer_dst = '0;
      m_seen = 0; m_phase = 0; m_src = 0; m_dst = 0;
      foreach (m_reg[i]) m_reg[i] = '0;

      // Reset state.
      s = idle_stim(5); s.clr = 1; drive(s); drive(s);

      // ext_data 15 into register 2, read back through index 3.
      s = idle_stim(3); s.ext_out = 1; s.ext_data = 15; s.in_en[2] = 1; drive(s);
      drive(idle_stim(3));

      // Register 2 into register 5, then a two-source conflict.
      s = idle_stim(6); s.out_en[2] = 1; s.in_en[5] = 1; drive(s);
      s = idle_stim(6); s.out_en[2] = 1; s.out_en[7] = 1; drive(s);
      drive(idle_stim(6)); drive(idle_stim(6));
      s = idle_stim(6); s.cclr = 1; drive(s);
      drive(idle_stim(6));

      // Register 2 into register 9 by transfer.
      s = idle_stim(10); s.start = 1; s.src = 3; s.dst = 10; drive(s);
      repeat (3) drive(idle_stim(10));

      // Preload register 4, then a transfer racing a manual load of it.
      s = idle_stim(5); s.ext_out = 1; s.ext_data = 77; s.in_en[4] = 1; drive(s);
      s = idle_stim(2); s.start = 1; s.src = 1; s.dst = 2; s.ext_data = 32'hDEADBEEF; drive(s);
      s.in_en[4] = 1; drive(s);
      s.in_en[4] = 0; s.rd_addr = 5; drive(s);
      s.start = 0; drive(s);
      drive(idle_stim(2));

      // Invalid destination, then invalid source.
      s = idle_stim(10); s.start = 1; s.src = 3; s.dst = 0; s.ext_data = 32'h1234; drive(s);
      s.start = 0; repeat (3) drive(s);
      s = idle_stim(2); s.start = 1; s.src = SW'(NR + 1); s.dst = 2; drive(s);
      s.start = 0; repeat (3) drive(s);

      // clr during the bus cycle of a transfer.
      s = idle_stim(6); s.start = 1; s.src = 3; s.dst = 6; drive(s);
      s = idle_stim(3); s.clr = 1; drive(s);
      repeat (3) drive(idle_stim(6));

      // Random traffic.
      repeat (400) drive(rand_stim());

      @(negedge clk);
      #1;
      check("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
